seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the single 4-digit seven-segment display between NUM_REQ requesters, for example the score, the countdown timer and the song-select number. It produces the 16-bit decimal value driven into the display driver's displayed_number input.
- Arbitration is fixed-priority; requester 0 is highest.
- A minimum hold time stops the digits flickering between sources.
- Values are clamped to the 4-digit decimal range.

Parameters:
NUM_REQ, 3, number of requesters (2..4).
HOLD_CYCLES, 100_000_000, minimum grant duration in clocks (1 s at 100 MHz); must be >= 1.
IDLE_VALUE, 0, value shown when no requester owns the display; must be <= 9999.

Ports:
clock_100Mhz  input  1  system clock, 100 MHz.
reset_n  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  level request per requester; bit 0 is highest priority.
req_value  input  16*NUM_REQ  flattened values; slice i is [16*i+15:16*i].
grant  output  NUM_REQ  one-hot owner, or all zeros when idle.
active_src  output  2  index of the owner; 0 when idle.
busy  output  1  high whenever grant is non-zero.
displayed_number  output  16  clamped value for the display driver.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of the clock):
  - state = IDLE, hold counter = 0.
  - grant = 0, active_src = 0, busy = 0, displayed_number = IDLE_VALUE.
- All outputs are registered.
- Clamp rule: clamp(v) = (v > 9999) ? 9999 : v. It applies to every value loaded into displayed_number.
- The winner is the lowest-index i with req[i] = 1.
- States: IDLE, HOLD, OWN.
- IDLE:
  - If any req is high at an edge: on that edge grant = onehot(winner), active_src = winner, displayed_number = clamp(req_value[winner]).
  - On the same edge, counter = HOLD_CYCLES-1 and state goes to HOLD. Grant latency is 1 clock from req assertion.
  - Otherwise displayed_number stays at IDLE_VALUE.
- HOLD:
  - Ownership is fixed; no preemption, even by a higher-priority requester.
  - While req[owner] = 1, displayed_number = clamp(req_value[owner]) every edge (1-clock latency).
  - If req[owner] = 0, displayed_number freezes at its last value and grant stays asserted.
  - When counter != 0: decrement by 1.
  - When counter == 0: re-arbitrate on that edge.
    - No req high: go to IDLE, grant = 0, displayed_number = IDLE_VALUE.
    - req[owner] high and no higher-priority req high: go to OWN, owner unchanged.
    - Any other winner: grant passes to it, displayed_number loads its clamped value, counter reloads, and state stays HOLD.
  - The grant therefore lasts at least HOLD_CYCLES clocks.
- OWN:
  - Each edge, displayed_number tracks clamp(req_value[owner]).
  - If a requester with a lower index than the owner raises req: preempt on that edge. The new owner is granted and loaded as described for HOLD, and the state goes to HOLD.
  - Else if req[owner] = 0: re-arbitrate exactly as on HOLD expiry.
  - Lower-priority requests wait.
- Simultaneous events:
  - If the owner drops its request on the same edge a higher-priority requester arrives, the higher-priority requester wins.
  - Requests with index >= NUM_REQ do not exist.
  - An all-zero req in OWN always returns to IDLE.
- grant is never multi-hot, and busy equals |grant.
- Reset in mid-operation abandons the hold immediately, with no flush.

Decomposition:
- Package seg_arb_pkg:
  - state enum {IDLE, HOLD, OWN}.
  - constant MAX_DISPLAY = 16'd9999.
  - clamp function.
  - constant SRC_W = 2.
- Sub-module seg_arb_prio_enc: combinational lowest-index-first encoder.
  - Inputs: req, plus a mask that limits the search to indices below the owner, used for the preemption check.
  - Outputs: found, index.
  - It is instantiated twice: once unmasked, once masked.

Test Plan:
(All directed tests use HOLD_CYCLES=4, NUM_REQ=3, IDLE_VALUE=0.)
1. Assert reset_n=0 with no clock running -> grant=000, busy=0, active_src=0, displayed_number=0; they stay there after release with req=000.
2. In IDLE, req=010 and value1=1234 -> next edge grant=010, active_src=1, displayed_number=1234. Then value1 changes to 1300 -> displayed_number=1300 one edge later.
3. Requester 2 owns in HOLD; req[0] rises 1 clock after grant with value0=42 -> grant stays 100 until the 4th edge after the original grant; on that edge grant=001, displayed_number=42.
4. req=001, value0=12000 -> displayed_number=9999; value0=65535 -> 9999; value0=9999 -> 9999; value0=0 -> 0.
5. Owner 1 drops req 1 clock into HOLD with the last value 77, no other requests -> displayed_number stays 77 and grant=010 until hold expiry; then grant=000, busy=0, displayed_number=0.
6. Requester 2 in OWN, then req[1] rises with value1=500 -> preemption on the next edge: grant=010, displayed_number=500, a new 4-clock hold. reset_n=0 asserted mid-hold -> outputs take their reset values immediately.

Source files
------------

// File: rtl/seg_arb_pkg.sv
// Shared types, constants and the display clamp for the seven-segment arbiter.
// Latency: none (declarations only).
// Backpressure: none.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OWN  = 2'd2
  } state_t;

  localparam logic [15:0] MAX_DISPLAY = 16'd9999;
  localparam int          SRC_W       = 2;

  // The display has four decimal digits, so anything above 9999 saturates.
  function automatic logic [15:0] clamp(input logic [15:0] v);
    return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
  endfunction

endpackage

// File: rtl/seg_arb_prio_enc.sv
// Lowest-index-first priority encoder over req & mask.
// Latency: combinational.
// Backpressure: none.
// Ports: req/mask (NUM_REQ bits) in; found (any masked request) and index out.
module seg_arb_prio_enc
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [SRC_W-1:0]   index
);

  logic [NUM_REQ-1:0] cand;

  assign cand  = req & mask;
  assign found = |cand;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) index = SRC_W'(i);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner of the 4-digit display with a minimum grant hold time.
// Latency: 1 clock from req/req_value to grant/displayed_number; all outputs registered.
// Backpressure: none; losing requesters simply wait while their req stays high.
// Ports: clock_100Mhz, reset_n (async, active-low), req/req_value in;
//        grant (one-hot), active_src, busy, displayed_number out.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter logic [15:0] IDLE_VALUE  = 16'd0
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_value,
  output logic [NUM_REQ-1:0]     grant,
  output logic [SRC_W-1:0]       active_src,
  output logic                   busy,
  output logic [15:0]            displayed_number
);

  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        clamped [NUM_REQ];
  logic [NUM_REQ-1:0] all_mask, pre_mask;
  logic               any_found, pre_found;
  logic [SRC_W-1:0]   any_idx, pre_idx;
  logic               owner_req;

  // Decisions handed from the next-state logic to the output logic.
  logic               take;
  logic [SRC_W-1:0]   take_idx;
  logic               drop;

  logic [NUM_REQ-1:0] grant_d;
  logic [SRC_W-1:0]   src_d;
  logic [15:0]        disp_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      clamped[i] = clamp(req_value[16*i +: 16]);
    end
  end

  // Preemption only considers requesters strictly more important than the owner.
  always_comb begin
    all_mask = '1;
    pre_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pre_mask[i] = (SRC_W'(i) < active_src);
    end
  end

  seg_arb_prio_enc #(.NUM_REQ(NUM_REQ)) u_enc_any (
    .req   (req),
    .mask  (all_mask),
    .found (any_found),
    .index (any_idx)
  );

  seg_arb_prio_enc #(.NUM_REQ(NUM_REQ)) u_enc_pre (
    .req   (req),
    .mask  (pre_mask),
    .found (pre_found),
    .index (pre_idx)
  );

  assign owner_req = req[active_src];

  // State register.
  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    take_idx = any_idx;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_found) begin
          take    = 1'b1;
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!any_found) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (any_idx == active_src) begin
          state_d = OWN;
        end else begin
          take  = 1'b1;
          cnt_d = HOLD_LOAD;
        end
      end
      OWN: begin
        if (pre_found) begin
          take     = 1'b1;
          take_idx = pre_idx;
          state_d  = HOLD;
          cnt_d    = HOLD_LOAD;
        end else if (!owner_req) begin
          // Nothing above the owner is asking, so any winner here ranks below it.
          if (!any_found) begin
            drop    = 1'b1;
            state_d = IDLE;
          end else begin
            take    = 1'b1;
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs).
  always_comb begin
    grant_d = grant;
    src_d   = active_src;
    disp_d  = displayed_number;
    if (drop) begin
      grant_d = '0;
      src_d   = '0;
      disp_d  = IDLE_VALUE;
    end else if (take) begin
      grant_d = NUM_REQ'(1) << take_idx;
      src_d   = take_idx;
      disp_d  = clamped[take_idx];
    end else if ((state_q != IDLE) && owner_req) begin
      // A silent owner leaves the last value frozen on the display.
      disp_d = clamped[active_src];
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      grant            <= '0;
      active_src       <= '0;
      busy             <= 1'b0;
      displayed_number <= IDLE_VALUE;
    end else begin
      grant            <= grant_d;
      active_src       <= src_d;
      busy             <= |grant_d;
      displayed_number <= disp_d;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a cycle-by-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_display_arbiter;

  localparam int NUM_REQ = 3;
  localparam int HOLD    = 4;

  logic                  clk;
  logic                  clk_en;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]    grant;
  logic [1:0]            active_src;
  logic                  busy;
  logic [15:0]           displayed_number;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: an owner is locked for HOLD clocks after every new grant;
  // once unlocked the owner is simply the lowest-index active requester.
  int m_owner = -1;
  int m_since = 0;
  int m_disp  = 0;

  seg_display_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .IDLE_VALUE  (16'd0)
  ) dut (
    .clock_100Mhz     (clk),
    .reset_n          (reset_n),
    .req              (req),
    .req_value        (req_value),
    .grant            (grant),
    .active_src       (active_src),
    .busy             (busy),
    .displayed_number (displayed_number)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  function automatic int clampv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int val_of(input int i);
    return int'(req_value[16*i +: 16]);
  endfunction

  function automatic int lowest_req();
    for (int i = 0; i < NUM_REQ; i++) if (req[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_since = 0;
    m_disp  = 0;
  endtask

  task automatic model_step();
    int w;
    w = lowest_req();
    if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w; m_since = 0; m_disp = clampv(val_of(w));
      end
    end else if (m_since + 1 < HOLD) begin
      m_since++;
      if (req[m_owner]) m_disp = clampv(val_of(m_owner));
    end else begin
      if (w < 0) begin
        m_owner = -1; m_since = 0; m_disp = 0;
      end else if (w == m_owner) begin
        m_since = HOLD;
        m_disp  = clampv(val_of(m_owner));
      end else begin
        m_owner = w; m_since = 0; m_disp = clampv(val_of(w));
      end
    end
  endtask

  always @(negedge reset_n) model_reset();

  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check("model_grant", int'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
    check("model_src", int'(active_src), (m_owner < 0) ? 0 : m_owner);
    check("model_busy", int'(busy), (m_owner < 0) ? 0 : 1);
    check("model_disp", int'(displayed_number), m_disp);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [2:0] r, input int v0, input int v1, input int v2);
    req = r;
    req_value = {16'(v2), 16'(v1), 16'(v0)};
  endtask

  task automatic expect_out(input string name, input int g, input int s, input int d);
    check({name, "_grant"}, int'(grant), g);
    check({name, "_src"}, int'(active_src), s);
    check({name, "_busy"}, int'(busy), (g != 0) ? 1 : 0);
    check({name, "_disp"}, int'(displayed_number), d);
  endtask

  initial begin
    clk_en  = 1'b0;
    reset_n = 1'b0;
    set_in(3'b000, 0, 0, 0);

    // 1: reset with no clock, then release and idle.
    #3;
    expect_out("rst_noclk", 0, 0, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick(3);
    expect_out("idle", 0, 0, 0);

    // 2: simple grant and value tracking.
    set_in(3'b010, 0, 1234, 0);
    tick(1);
    expect_out("grant1", 2, 1, 1234);
    set_in(3'b010, 0, 1300, 0);
    tick(1);
    expect_out("track1", 2, 1, 1300);
    set_in(3'b000, 0, 0, 0);
    tick(5);
    expect_out("back_idle", 0, 0, 0);

    // 3: no preemption during hold.
    set_in(3'b100, 0, 0, 7);
    tick(1);
    expect_out("grant2", 4, 2, 7);
    set_in(3'b101, 42, 0, 7);
    tick(3);
    expect_out("hold_no_preempt", 4, 2, 7);
    tick(1);
    expect_out("hold_expiry_switch", 1, 0, 42);
    set_in(3'b000, 0, 0, 0);
    tick(6);

    // 4: clamp boundaries.
    set_in(3'b001, 12000, 0, 0);
    tick(1);
    check("clamp_12000", int'(displayed_number), 9999);
    set_in(3'b001, 65535, 0, 0);
    tick(1);
    check("clamp_65535", int'(displayed_number), 9999);
    set_in(3'b001, 9999, 0, 0);
    tick(1);
    check("clamp_9999", int'(displayed_number), 9999);
    set_in(3'b001, 0, 0, 0);
    tick(1);
    check("clamp_0", int'(displayed_number), 0);
    set_in(3'b000, 0, 0, 0);
    tick(6);

    // 5: owner goes silent inside the hold; value freezes until expiry.
    set_in(3'b010, 0, 77, 0);
    tick(1);
    set_in(3'b000, 0, 88, 0);
    tick(3);
    expect_out("frozen", 2, 1, 77);
    tick(1);
    expect_out("expire_idle", 0, 0, 0);

    // 6: preemption from OWN, then async reset mid-hold.
    set_in(3'b100, 0, 0, 5);
    tick(5);
    expect_out("own2", 4, 2, 5);
    set_in(3'b110, 0, 500, 5);
    tick(1);
    expect_out("preempt", 2, 1, 500);
    tick(1);
    #1 reset_n = 1'b0;
    #1;
    expect_out("rst_mid", 0, 0, 0);
    tick(2);
    set_in(3'b000, 0, 0, 0);
    reset_n = 1'b1;
    tick(2);
    expect_out("after_rst", 0, 0, 0);

    // Owner drops while a higher requester arrives in OWN: higher one wins.
    set_in(3'b010, 0, 10, 0);
    tick(5);
    set_in(3'b001, 20, 0, 0);
    tick(1);
    expect_out("drop_and_arrive", 1, 0, 20);
    set_in(3'b000, 0, 0, 0);
    tick(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
